npc_mc_sequencer: RTL and testbench
===================================

# npc_mc_sequencer

Parametrised multi-cycle control sequencer for the NPC core. It replaces the single-cycle "everything in one clock" flow with an explicit FSM. The FSM owns the PC, the latched instruction, load-data buffering and the retire counter. It talks to instruction and data memory through valid/ready handshakes, so IFU/LSU latency is arbitrary. IDU, ALU, BSU, GPR and CSR stay combinational/clocked peers; this block gates their writes and commits the next PC.

## Interface
Parameters:
- XLEN, 32, datapath/PC width
- RESET_PC, 32'h8000_0000, PC value after reset
- CNT_W, 64, retired-instruction counter width

Ports:
- clk  in  1  core clock
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- ifu_req_valid  out  1  fetch request
- ifu_req_ready  in  1  IFU accepts request
- ifu_req_addr  out  XLEN  fetch address (= pc)
- ifu_rsp_valid  in  1  instruction returned
- ifu_rsp_ready  out  1  sequencer accepts instruction
- ifu_rsp_inst  in  32  returned instruction
- inst  out  32  latched instruction to IDU/GPR/IMM/CSR
- pc  out  XLEN  architectural PC
- dec_mem_rd, dec_mem_wr  in  1  IDU load/store flags
- dec_w_en, dec_csr_w_en  in  1  IDU GPR/CSR write requests
- dec_jump  in  1  jal/jalr/taken branch
- dec_trap  in  1  ecall/mret
- dec_halt  in  1  ebreak
- jump_pc, trap_pc  in  XLEN  redirect targets
- lsu_req_valid  out  1  data access request (addr/wdata/ctrl from datapath)
- lsu_req_ready  in  1  LSU accepts
- lsu_rsp_valid  in  1  load data / store done
- lsu_rsp_data  in  XLEN  load data
- ld_data  out  XLEN  registered load data for writeback mux
- gpr_w_en, csr_w_en  out  1  gated write strobes
- commit  out  1  one-cycle retire pulse
- instret  out  CNT_W  retired count
- halted  out  1  sticky halt

## Operation
- States: FETCH_REQ, FETCH_WAIT, EXEC, MEM_REQ, MEM_WAIT, WB, HALT.
- FETCH_REQ: ifu_req_valid=1, ifu_req_addr=pc held stable. On ready, go to FETCH_WAIT.
- FETCH_WAIT: ifu_rsp_ready=1. On rsp_valid, latch inst and go to EXEC.
- EXEC: one cycle for decode and ALU settle.
  - dec_halt: go to HALT.
  - dec_mem_rd or dec_mem_wr: go to MEM_REQ.
  - Otherwise: go to WB.
- MEM_REQ: lsu_req_valid=1 until lsu_req_ready, then go to MEM_WAIT.
- MEM_WAIT: on lsu_rsp_valid, latch lsu_rsp_data into ld_data only for loads (stores leave ld_data unchanged), then go to WB.
- WB, single cycle:
  - gpr_w_en = dec_w_en; csr_w_en = dec_csr_w_en; commit=1; instret+1.
  - pc <= dec_trap ? trap_pc : dec_jump ? jump_pc : pc+4.
  - Go to FETCH_REQ.
- HALT: every strobe and valid stays 0; halted=1. Only reset leaves HALT. The ebreak is not committed.
- Strobes gpr_w_en, csr_w_en and commit are asserted only in WB.
- Redirect priority: trap > jump > sequential.
- pc+4 and instret wrap modulo 2^XLEN and 2^CNT_W.

## Timing
- Reset values:
  - pc=RESET_PC, inst=32'h0000_0013 (nop), ld_data=0, instret=0.
  - All valid/ready/strobe outputs 0, halted=0, state=FETCH_REQ.
- The first ifu_req_valid appears in the first clock after rst deasserts.
- Minimum latency with zero-wait memories:
  - ALU op: 4 cycles (FETCH_REQ, FETCH_WAIT, EXEC, WB).
  - Load/store: 6 cycles.
- Handshakes:
  - Request valid never drops before ready.
  - ifu_rsp_ready is asserted only in FETCH_WAIT; a response in any other state is ignored.
  - req and rsp in the same cycle are not accepted together: the response is sampled only from the WAIT state.
- Reset asserted mid-transaction forces the reset values immediately. No outstanding request is remembered.
- inst and ld_data are stable from EXEC (respectively WB) until the next fetch response is latched.

## Structure
- Shared package npc_pkg holds:
  - state enum (3-bit encoding, as listed above)
  - NOP_INST constant
  - default RESET_PC
- One natural sub-module, npc_instret_cnt (CNT_W counter with increment enable). Everything else stays flat in one FSM plus registers.

## Test plan
- Reset release, zero-wait IFU returning addi: req addr 8000_0000; commit after 4 cycles; pc=8000_0004; instret=1; gpr_w_en high exactly in WB.
- IFU ready stalls 3 cycles and rsp stalls 2: req_valid/addr held stable; commit at cycle 9; no duplicate latch.
- Load with LSU rsp data DEAD_BEEF after 2 waits: ld_data=DEAD_BEEF in WB; gpr_w_en=1. Store: gpr_w_en=0 (dec_w_en=0); ld_data unchanged.
- dec_jump=1, jump_pc=8000_0100 with dec_trap=1, trap_pc=8000_0200: pc=8000_0200. With trap deasserted: pc=8000_0100.
- dec_halt in EXEC: no commit; halted=1; no further ifu_req_valid for 100 cycles; rst low/high restarts fetch at RESET_PC.
- rst asserted during MEM_WAIT: all outputs to reset values in that cycle, async. instret from a preloaded 2^CNT_W-1 wraps to 0 on commit.

Source files
------------

// File: rtl/npc_pkg.sv
`default_nettype none
// ============================================================================
// Package     : npc_pkg
// Description : Shared types and constants for the NPC multi-cycle sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package npc_pkg;

  // Sequencer states, 3-bit encoding in listed order
  typedef enum logic [2:0] {
    S_FETCH_REQ  = 3'd0,
    S_FETCH_WAIT = 3'd1,
    S_EXEC       = 3'd2,
    S_MEM_REQ    = 3'd3,
    S_MEM_WAIT   = 3'd4,
    S_WB         = 3'd5,
    S_HALT       = 3'd6
  } npc_state_e;

  // addi x0, x0, 0 -- the instruction register resets to a harmless nop
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

  // An instruction needs the LSU if it is either a load or a store
  function automatic logic is_mem_op(input logic i_rd, input logic i_wr);
    return i_rd | i_wr;
  endfunction

endpackage
`default_nettype wire

// File: rtl/npc_instret_cnt.sv
`default_nettype none
// ============================================================================
// Module      : npc_instret_cnt
// Description : Retired-instruction counter, wraps modulo 2^CNT_W.
// Revision    : 1.0 - initial release
// ============================================================================
module npc_instret_cnt #(
  parameter int unsigned CNT_W = 64
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  // Count one per retire pulse; natural overflow gives the wrap
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/npc_mc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : npc_mc_sequencer
// Description : Multi-cycle control FSM for the NPC core. Owns PC, latched
//               instruction, load-data buffer and retire counter; talks to
//               IFU/LSU via valid/ready and gates GPR/CSR writes to WB.
// Revision    : 1.0 - initial release
// ============================================================================
module npc_mc_sequencer
  import npc_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC),
  parameter int unsigned     CNT_W    = 64
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  // instruction fetch
  output logic             o_ifu_req_valid,
  input  logic             i_ifu_req_ready,
  output logic [XLEN-1:0]  o_ifu_req_addr,
  input  logic             i_ifu_rsp_valid,
  output logic             o_ifu_rsp_ready,
  input  logic [31:0]      i_ifu_rsp_inst,
  // architectural state to the datapath
  output logic [31:0]      o_inst,
  output logic [XLEN-1:0]  o_pc,
  // decoder flags
  input  logic             i_dec_mem_rd,
  input  logic             i_dec_mem_wr,
  input  logic             i_dec_w_en,
  input  logic             i_dec_csr_w_en,
  input  logic             i_dec_jump,
  input  logic             i_dec_trap,
  input  logic             i_dec_halt,
  input  logic [XLEN-1:0]  i_jump_pc,
  input  logic [XLEN-1:0]  i_trap_pc,
  // data memory
  output logic             o_lsu_req_valid,
  input  logic             i_lsu_req_ready,
  input  logic             i_lsu_rsp_valid,
  input  logic [XLEN-1:0]  i_lsu_rsp_data,
  output logic [XLEN-1:0]  o_ld_data,
  // write gating and retire
  output logic             o_gpr_w_en,
  output logic             o_csr_w_en,
  output logic             o_commit,
  output logic [CNT_W-1:0] o_instret,
  output logic             o_halted
);

  npc_state_e      r_state;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_inst;
  logic [XLEN-1:0] r_ld_data;
  logic            r_ifu_req_valid;
  logic            r_ifu_rsp_ready;
  logic            r_lsu_req_valid;
  logic            r_commit;      // high exactly while in WB
  logic            r_halted;
  logic [XLEN-1:0] w_pc_seq;
  logic [XLEN-1:0] w_pc_next;

  // Next PC with trap > jump > sequential priority; sequential wraps naturally
  assign w_pc_seq  = r_pc + XLEN'(4);
  assign w_pc_next = i_dec_trap ? i_trap_pc : (i_dec_jump ? i_jump_pc : w_pc_seq);

  // Sequencer FSM: state, datapath registers and registered handshake outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state         <= S_FETCH_REQ;
      r_pc            <= RESET_PC;
      r_inst          <= NOP_INST;
      r_ld_data       <= '0;
      r_ifu_req_valid <= 1'b0;
      r_ifu_rsp_ready <= 1'b0;
      r_lsu_req_valid <= 1'b0;
      r_commit        <= 1'b0;
      r_halted        <= 1'b0;
    end else begin
      r_commit <= 1'b0;
      case (r_state)
        S_FETCH_REQ: begin
          // Raise the request (first cycle after reset) and hold it until taken
          r_ifu_req_valid <= 1'b1;
          if (r_ifu_req_valid && i_ifu_req_ready) begin
            r_ifu_req_valid <= 1'b0;
            r_ifu_rsp_ready <= 1'b1;
            r_state         <= S_FETCH_WAIT;
          end
        end
        S_FETCH_WAIT: begin
          if (i_ifu_rsp_valid) begin
            r_inst          <= i_ifu_rsp_inst;
            r_ifu_rsp_ready <= 1'b0;
            r_state         <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (i_dec_halt) begin
            r_halted <= 1'b1;
            r_state  <= S_HALT;
          end else if (is_mem_op(i_dec_mem_rd, i_dec_mem_wr)) begin
            r_lsu_req_valid <= 1'b1;
            r_state         <= S_MEM_REQ;
          end else begin
            r_commit <= 1'b1;
            r_state  <= S_WB;
          end
        end
        S_MEM_REQ: begin
          if (i_lsu_req_ready) begin
            r_lsu_req_valid <= 1'b0;
            r_state         <= S_MEM_WAIT;
          end
        end
        S_MEM_WAIT: begin
          if (i_lsu_rsp_valid) begin
            // Stores complete here too but must not disturb the load buffer
            if (i_dec_mem_rd) begin
              r_ld_data <= i_lsu_rsp_data;
            end
            r_commit <= 1'b1;
            r_state  <= S_WB;
          end
        end
        S_WB: begin
          r_pc            <= w_pc_next;
          r_ifu_req_valid <= 1'b1;
          r_state         <= S_FETCH_REQ;
        end
        S_HALT: begin
          r_ifu_req_valid <= 1'b0;
          r_ifu_rsp_ready <= 1'b0;
          r_lsu_req_valid <= 1'b0;
          r_halted        <= 1'b1;
        end
        default: begin
          r_ifu_req_valid <= 1'b0;
          r_ifu_rsp_ready <= 1'b0;
          r_lsu_req_valid <= 1'b0;
          r_state         <= S_FETCH_REQ;
        end
      endcase
    end
  end

  npc_instret_cnt #(
    .CNT_W (CNT_W)
  ) u_instret (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (r_commit),
    .o_cnt   (o_instret)
  );

  assign o_ifu_req_valid = r_ifu_req_valid;
  assign o_ifu_req_addr  = r_pc;
  assign o_ifu_rsp_ready = r_ifu_rsp_ready;
  assign o_inst          = r_inst;
  assign o_pc            = r_pc;
  assign o_lsu_req_valid = r_lsu_req_valid;
  assign o_ld_data       = r_ld_data;
  // Decoder requests pass through only during the single WB cycle
  assign o_gpr_w_en      = r_commit & i_dec_w_en;
  assign o_csr_w_en      = r_commit & i_dec_csr_w_en;
  assign o_commit        = r_commit;
  assign o_halted        = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_npc_mc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_npc_mc_sequencer
// Description : Self-checking bench: directed vector table, randomized
//               instruction stream against a transaction-level model, and
//               hand-written halt / reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_npc_mc_sequencer;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk;
  logic        rst_n;
  logic        ifu_req_ready, ifu_rsp_valid;
  logic [31:0] ifu_rsp_inst;
  logic        dec_mem_rd, dec_mem_wr, dec_w_en, dec_csr_w_en;
  logic        dec_jump, dec_trap, dec_halt;
  logic [31:0] jump_pc, trap_pc;
  logic        lsu_req_ready, lsu_rsp_valid;
  logic [31:0] lsu_rsp_data;

  logic        ifu_req_valid, ifu_rsp_ready, lsu_req_valid;
  logic [31:0] ifu_req_addr, inst, pc, ld_data;
  logic        gpr_w_en, csr_w_en, commit, halted;
  logic [63:0] instret;

  // narrow-counter instance, shares all inputs, used for wrap checking
  logic        s_ifu_req_valid, s_ifu_rsp_ready, s_lsu_req_valid;
  logic [31:0] s_ifu_req_addr, s_inst, s_pc, s_ld_data;
  logic        s_gpr_w_en, s_csr_w_en, s_commit, s_halted;
  logic [2:0]  s_instret;

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] m_pc;
  logic [63:0] m_cnt;
  logic [31:0] m_ld;

  npc_mc_sequencer u_dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .o_ifu_req_valid(ifu_req_valid), .i_ifu_req_ready(ifu_req_ready),
    .o_ifu_req_addr(ifu_req_addr), .i_ifu_rsp_valid(ifu_rsp_valid),
    .o_ifu_rsp_ready(ifu_rsp_ready), .i_ifu_rsp_inst(ifu_rsp_inst),
    .o_inst(inst), .o_pc(pc),
    .i_dec_mem_rd(dec_mem_rd), .i_dec_mem_wr(dec_mem_wr), .i_dec_w_en(dec_w_en),
    .i_dec_csr_w_en(dec_csr_w_en), .i_dec_jump(dec_jump), .i_dec_trap(dec_trap),
    .i_dec_halt(dec_halt), .i_jump_pc(jump_pc), .i_trap_pc(trap_pc),
    .o_lsu_req_valid(lsu_req_valid), .i_lsu_req_ready(lsu_req_ready),
    .i_lsu_rsp_valid(lsu_rsp_valid), .i_lsu_rsp_data(lsu_rsp_data),
    .o_ld_data(ld_data), .o_gpr_w_en(gpr_w_en), .o_csr_w_en(csr_w_en),
    .o_commit(commit), .o_instret(instret), .o_halted(halted)
  );

  npc_mc_sequencer #(.CNT_W(3)) u_dut_w (
    .i_clk(clk), .i_rst_n(rst_n),
    .o_ifu_req_valid(s_ifu_req_valid), .i_ifu_req_ready(ifu_req_ready),
    .o_ifu_req_addr(s_ifu_req_addr), .i_ifu_rsp_valid(ifu_rsp_valid),
    .o_ifu_rsp_ready(s_ifu_rsp_ready), .i_ifu_rsp_inst(ifu_rsp_inst),
    .o_inst(s_inst), .o_pc(s_pc),
    .i_dec_mem_rd(dec_mem_rd), .i_dec_mem_wr(dec_mem_wr), .i_dec_w_en(dec_w_en),
    .i_dec_csr_w_en(dec_csr_w_en), .i_dec_jump(dec_jump), .i_dec_trap(dec_trap),
    .i_dec_halt(dec_halt), .i_jump_pc(jump_pc), .i_trap_pc(trap_pc),
    .o_lsu_req_valid(s_lsu_req_valid), .i_lsu_req_ready(lsu_req_ready),
    .i_lsu_rsp_valid(lsu_rsp_valid), .i_lsu_rsp_data(lsu_rsp_data),
    .o_ld_data(s_ld_data), .o_gpr_w_en(s_gpr_w_en), .o_csr_w_en(s_csr_w_en),
    .o_commit(s_commit), .o_instret(s_instret), .o_halted(s_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic        rd, wr, w_en, csr, jump, trap;
    logic [31:0] jpc, tpc, ldata;
    int          req_st, rsp_st, lreq_st, lrsp_st;
    logic [31:0] exp_pc, exp_ld;
  } vec_t;

  vec_t tbl [10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    $display("reset check: %s", tag);
    chk("rst pc", pc, RST_PC);
    chk("rst inst", inst, 32'h0000_0013);
    chk("rst ld_data", ld_data, 0);
    chk("rst instret", instret, 0);
    chk("rst instret narrow", s_instret, 0);
    chk("rst ifu_req_valid", ifu_req_valid, 0);
    chk("rst ifu_rsp_ready", ifu_rsp_ready, 0);
    chk("rst lsu_req_valid", lsu_req_valid, 0);
    chk("rst strobes", {gpr_w_en, csr_w_en, commit}, 0);
    chk("rst halted", halted, 0);
  endtask

  task automatic set_dec(input logic rd, wr, w_en, csr, jump, trap, halt,
                         input logic [31:0] jpc, tpc);
    dec_mem_rd = rd; dec_mem_wr = wr; dec_w_en = w_en; dec_csr_w_en = csr;
    dec_jump = jump; dec_trap = trap; dec_halt = halt; jump_pc = jpc; trap_pc = tpc;
  endtask

  // Fetch phase: returns with the sequencer sitting in EXEC
  task automatic do_fetch(input logic [31:0] inst_v, input int req_st, input int rsp_st);
    int n;
    logic ok;
    logic [31:0] prev_inst;
    n = 0;
    while (!ifu_req_valid && n < 8) begin step(); n++; end
    chk("fetch req_valid", ifu_req_valid, 1);
    chk("fetch addr", ifu_req_addr, m_pc);
    prev_inst = inst;
    ok = 1'b1;
    for (int i = 0; i < req_st; i++) begin
      // a stray response before the request is taken must be ignored
      ifu_rsp_valid = 1'b1; ifu_rsp_inst = 32'hBAD0_0000 | i;
      step();
      if (!ifu_req_valid || ifu_req_addr !== m_pc || inst !== prev_inst || ifu_rsp_ready) ok = 1'b0;
    end
    ifu_rsp_valid = 1'b0;
    if (req_st > 0) chk("req held during stall", ok, 1);
    ifu_req_ready = 1'b1;
    step();
    ifu_req_ready = 1'b0;
    chk("rsp_ready in wait", ifu_rsp_ready, 1);
    chk("req dropped after accept", ifu_req_valid, 0);
    ok = 1'b1;
    for (int i = 0; i < rsp_st; i++) begin
      step();
      if (!ifu_rsp_ready || ifu_req_valid || inst !== prev_inst) ok = 1'b0;
    end
    if (rsp_st > 0) chk("rsp wait stable", ok, 1);
    ifu_rsp_valid = 1'b1; ifu_rsp_inst = inst_v;
    step();
    chk("inst latched", inst, inst_v);
    chk("rsp_ready dropped", ifu_rsp_ready, 0);
    // keep a bogus response up through EXEC; it must not be latched again
    ifu_rsp_inst = ~inst_v;
  endtask

  // EXEC and optional memory phase: returns with the sequencer in WB
  task automatic do_exec(input logic is_mem, input logic [31:0] ldata,
                         input int lreq_st, input int lrsp_st);
    logic ok;
    chk("no commit in EXEC", commit, 0);
    step();
    ifu_rsp_valid = 1'b0;
    if (is_mem) begin
      chk("lsu_req_valid", lsu_req_valid, 1);
      ok = 1'b1;
      for (int i = 0; i < lreq_st; i++) begin
        step();
        if (!lsu_req_valid || commit) ok = 1'b0;
      end
      lsu_req_ready = 1'b1;
      step();
      lsu_req_ready = 1'b0;
      chk("lsu req dropped", lsu_req_valid, 0);
      for (int i = 0; i < lrsp_st; i++) begin
        step();
        if (lsu_req_valid || commit) ok = 1'b0;
      end
      chk("lsu phase quiet", ok, 1);
      lsu_rsp_valid = 1'b1; lsu_rsp_data = ldata;
      step();
      lsu_rsp_valid = 1'b0; lsu_rsp_data = $urandom;
    end
  endtask

  task automatic do_wb(input logic exp_gpr, input logic exp_csr,
                       input logic [31:0] exp_pc, input logic [31:0] exp_ld,
                       input logic [31:0] exp_inst);
    chk("commit in WB", commit, 1);
    chk("gpr_w_en in WB", gpr_w_en, exp_gpr);
    chk("csr_w_en in WB", csr_w_en, exp_csr);
    chk("ld_data in WB", ld_data, exp_ld);
    chk("inst stable in WB", inst, exp_inst);
    step();
    m_cnt = m_cnt + 1;
    m_pc  = exp_pc;
    m_ld  = exp_ld;
    chk("commit one pulse", {commit, gpr_w_en, csr_w_en}, 0);
    chk("pc after WB", pc, m_pc);
    chk("instret", instret, m_cnt);
    chk("instret narrow wrap", s_instret, m_cnt[2:0]);
  endtask

  task automatic run_vec(input vec_t v);
    set_dec(v.rd, v.wr, v.w_en, v.csr, v.jump, v.trap, 1'b0, v.jpc, v.tpc);
    do_fetch(v.inst, v.req_st, v.rsp_st);
    do_exec(v.rd | v.wr, v.ldata, v.lreq_st, v.lrsp_st);
    do_wb(v.w_en, v.csr, v.exp_pc, v.exp_ld, v.inst);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    logic ok;
    logic [63:0] cnt_hold;

    tbl[0] = '{32'h0010_0093, 0,0,1,0,0,0, 0, 0, 0, 0,0,0,0, 32'h8000_0004, 32'h0};
    tbl[1] = '{32'h0020_8113, 0,0,1,0,0,0, 0, 0, 0, 3,2,0,0, 32'h8000_0008, 32'h0};
    tbl[2] = '{32'h0000_a183, 1,0,1,0,0,0, 0, 0, 32'hDEAD_BEEF, 0,0,0,2, 32'h8000_000C, 32'hDEAD_BEEF};
    tbl[3] = '{32'h0030_a023, 0,1,0,0,0,0, 0, 0, 32'h1234_5678, 1,0,1,1, 32'h8000_0010, 32'hDEAD_BEEF};
    tbl[4] = '{32'h0000_0073, 0,0,0,0,1,1, 32'h8000_0100, 32'h8000_0200, 0, 0,0,0,0, 32'h8000_0200, 32'hDEAD_BEEF};
    tbl[5] = '{32'h1000_006f, 0,0,1,0,1,0, 32'h8000_0100, 32'h8000_0200, 0, 0,1,0,0, 32'h8000_0100, 32'hDEAD_BEEF};
    tbl[6] = '{32'h3052_9073, 0,0,0,1,0,0, 0, 0, 0, 0,0,0,0, 32'h8000_0104, 32'hDEAD_BEEF};
    tbl[7] = '{32'h0000_a203, 1,0,1,0,0,1, 0, 32'h8000_0300, 32'hCAFE_F00D, 2,1,3,0, 32'h8000_0300, 32'hCAFE_F00D};
    tbl[8] = '{32'h0000_006f, 0,0,0,0,1,0, 32'hFFFF_FFFC, 0, 0, 0,0,0,0, 32'hFFFF_FFFC, 32'hCAFE_F00D};
    tbl[9] = '{32'h0010_0093, 0,0,1,0,0,0, 0, 0, 0, 0,0,0,0, 32'h0000_0000, 32'hCAFE_F00D};

    ifu_req_ready = 0; ifu_rsp_valid = 0; ifu_rsp_inst = 0;
    lsu_req_ready = 0; lsu_rsp_valid = 0; lsu_rsp_data = 0;
    set_dec(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    step(); step();
    check_reset("power-on");
    rst_n = 1'b1;
    m_pc = RST_PC; m_cnt = 0; m_ld = 0;

    // directed vectors
    foreach (tbl[i]) run_vec(tbl[i]);

    // randomized instruction stream against the transaction-level model
    for (int k = 0; k < 40; k++) begin
      int kind;
      kind      = $urandom_range(0, 3);
      v.inst    = $urandom;
      v.rd      = (kind == 1);
      v.wr      = (kind == 2);
      v.w_en    = (kind == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      v.csr     = 1'($urandom_range(0, 1));
      v.jump    = ($urandom_range(0, 3) == 0);
      v.trap    = ($urandom_range(0, 5) == 0);
      v.jpc     = $urandom & 32'hFFFF_FFFC;
      v.tpc     = $urandom & 32'hFFFF_FFFC;
      v.ldata   = $urandom;
      v.req_st  = $urandom_range(0, 3);
      v.rsp_st  = $urandom_range(0, 3);
      v.lreq_st = $urandom_range(0, 3);
      v.lrsp_st = $urandom_range(0, 3);
      v.exp_pc  = v.trap ? v.tpc : (v.jump ? v.jpc : m_pc + 32'd4);
      v.exp_ld  = v.rd ? v.ldata : m_ld;
      run_vec(v);
    end

    // ebreak: never committed, sequencer parks in HALT
    set_dec(0, 0, 1, 1, 0, 0, 1, 0, 0);
    do_fetch(32'h0010_0073, 0, 0);
    chk("no commit in EXEC (halt)", commit, 0);
    step();
    ifu_rsp_valid = 1'b0;
    chk("halted", halted, 1);
    cnt_hold = m_cnt;
    ok = 1'b1;
    ifu_req_ready = 1'b1; lsu_req_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      ifu_rsp_valid = 1'($urandom_range(0, 1));
      lsu_rsp_valid = 1'($urandom_range(0, 1));
      step();
      if (ifu_req_valid || ifu_rsp_ready || lsu_req_valid || commit ||
          gpr_w_en || csr_w_en || !halted) ok = 1'b0;
    end
    chk("halt quiet 100 cycles", ok, 1);
    chk("halt instret frozen", instret, cnt_hold);
    ifu_req_ready = 0; lsu_req_ready = 0; ifu_rsp_valid = 0; lsu_rsp_valid = 0;

    // reset leaves HALT and fetch restarts at the reset PC
    #2 rst_n = 1'b0;
    #1 check_reset("from halt");
    step();
    rst_n = 1'b1;
    m_pc = RST_PC; m_cnt = 0; m_ld = 0;
    run_vec(tbl[0]);

    // reset while a load sits in MEM_WAIT: immediate, nothing remembered
    set_dec(1, 0, 1, 1, 0, 0, 0, 0, 0);
    do_fetch(32'h0000_a283, 0, 0);
    chk("no commit in EXEC (ld)", commit, 0);
    step();
    ifu_rsp_valid = 1'b0;
    lsu_req_ready = 1'b1;
    step();
    lsu_req_ready = 1'b0;
    chk("in MEM_WAIT", lsu_req_valid, 0);
    lsu_rsp_data = 32'h5555_AAAA;
    #2 rst_n = 1'b0;
    #1 check_reset("mid MEM_WAIT");
    lsu_rsp_valid = 1'b1;
    step();
    lsu_rsp_valid = 1'b0;
    rst_n = 1'b1;
    m_pc = RST_PC; m_cnt = 0; m_ld = 0;
    run_vec(tbl[0]);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
